// File: rtl/state_permuter.sv
// state_permuter: iterated lane permutation over an N x N state.
// Build macro STATE_PERMUTER_ROTATE_EN adds a per-lane left rotation.
module state_permuter #(
   parameter int N     = 5,
   parameter int W     = 1,
   parameter int CNT_W = 5
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [N*N*W-1:0]   in_data,
   input  logic [CNT_W-1:0]   in_passes,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [N*N*W-1:0]   out_data,
   output logic               busy
);

   localparam int DW = N * N * W;
   localparam int H  = (N + 1) / 2;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } stateT;

   stateT            st;
   stateT            stNext;
   logic [DW-1:0]    stateReg;
   logic [DW-1:0]    passData;
   logic [CNT_W-1:0] cnt;
   logic             accept;

   // Logical (i,j) is centred: (H,H) offset wraps onto flat row/col.
   function automatic int flatIdx(input int i, input int j);
      return ((i + N - H) % N) * N + ((j + N - H) % N);
   endfunction

`ifdef STATE_PERMUTER_ROTATE_EN
   function automatic logic [W-1:0] rotl(
      input logic [W-1:0] x,
      input int           r
   );
      logic [2*W-1:0] t;
      t = {x, x} << r;
      return t[2*W-1:W];
   endfunction
`endif

   // One pass: lane (i,j) moves to (j, 2i+3j mod N); int math never overflows.
   always_comb begin
      passData = '0;
      for (int i = 0; i < N; i++) begin
         for (int j = 0; j < N; j++) begin
`ifdef STATE_PERMUTER_ROTATE_EN
            passData[flatIdx(j, (2 * i + 3 * j) % N) * W +: W] =
               rotl(stateReg[flatIdx(i, j) * W +: W], (i * N + j) % W);
`else
            passData[flatIdx(j, (2 * i + 3 * j) % N) * W +: W] =
               stateReg[flatIdx(i, j) * W +: W];
`endif
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) st <= IDLE;
      else        st <= stNext;
   end

   // Next state and handshake outputs; a DONE handshake never overlaps a new accept.
   always_comb begin
      stNext    = st;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      accept    = 1'b0;
      unique case (st)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               accept = 1'b1;
               stNext = (in_passes != '0) ? RUN : DONE;
            end
         end
         RUN: begin
            busy = 1'b1;
            if (cnt == CNT_W'(1)) stNext = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) stNext = IDLE;
         end
         default: stNext = IDLE;
      endcase
   end

   // Load the job on accept, then one pass and one count-down per RUN cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stateReg <= '0;
         cnt      <= '0;
      end else if (accept) begin
         stateReg <= in_data;
         cnt      <= in_passes;
      end else if (st == RUN) begin
         stateReg <= passData;
         cnt      <= cnt - CNT_W'(1);
      end
   end

   assign out_data = stateReg;

endmodule

// File: doc/state_permuter.md
STATE_PERMUTER -- requirements
Module: state_permuter

Interface
REQ-001 Parameter N, default 5: plane side; state is N x N lanes; N SHALL be 2..16.
REQ-002 Parameter W, default 1: lane width in bits; W SHALL be >= 1.
REQ-003 Parameter CNT_W, default 5: width of pass count.
REQ-004 clk  input  1  rising-edge clock, the only clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid  input  1  in_data/in_passes valid.
REQ-007 in_ready  output  1  block can accept a job.
REQ-008 in_data  input  N*N*W  flat state; lane at flat index k occupies bits [k*W +: W].
REQ-009 in_passes  input  CNT_W  number of permutation passes P to apply.
REQ-010 out_valid  output  1  out_data holds the result.
REQ-011 out_ready  input  1  consumer accepts the result.
REQ-012 out_data  output  N*N*W  permuted state.
REQ-013 busy  output  1  high in RUN or DONE.

Function
REQ-014 H SHALL be ceil(N/2); logical (i,j) SHALL map to flat index ((i+N-H) mod N)*N + ((j+N-H) mod N).
REQ-015 One pass SHALL move the source lane at logical (i,j) to logical (j, (2i+3j) mod N) for all i,j in 0..N-1.
REQ-016 Pass arithmetic SHALL be done at widths that cannot overflow for N <= 16; the result is purely a function of state, with no dependence on timing.
REQ-017 FSM states SHALL be IDLE, RUN and DONE.
REQ-018 IDLE: in_ready=1; on in_valid, the block SHALL load in_data into the state register and P into the counter, then go to RUN if P>0, else to DONE.
REQ-019 RUN: every cycle the block SHALL apply one pass to the state register and decrement the counter; when the counter is 1, it SHALL go to DONE.
REQ-020 DONE: out_valid=1 and out_data=state register; the block SHALL hold both stable until out_ready=1, then return to IDLE.
REQ-021 Latency: out_valid SHALL first be high P+1 cycles after the accept cycle, so P=0 gives 1 cycle.
REQ-022 in_ready SHALL be 0 outside IDLE; in_valid outside IDLE SHALL be ignored, with no queuing.
REQ-023 out_ready outside DONE SHALL be ignored.
REQ-024 out_valid=1 with out_ready=1 and in_valid=1 in the same cycle: the block SHALL go to IDLE only; the new job SHALL be accepted no earlier than the next cycle.
REQ-025 P = 2^CNT_W-1 SHALL be handled with no counter wrap.
REQ-026 out_data SHALL equal the state register in all states.

Reset
REQ-027 rst_n low SHALL immediately force IDLE, counter=0, state register=0, out_valid=0, busy=0, in_ready=1.
REQ-028 Reset asserted mid-RUN or mid-DONE SHALL discard the job with no output.
REQ-029 After rst_n deasserts, the first acceptance SHALL be possible on the next rising edge.

Configuration
REQ-030 Macro STATE_PERMUTER_ROTATE_EN.
- Defined: each pass SHALL also rotate the moved lane left by ((i*N + j) mod W) bits, with (i,j) being the source logical coordinate.
- Undefined: no rotation; the pass is a pure lane move.
- Interface and timing SHALL be identical either way.

Verification (N=5, W=1 unless stated; macro undefined unless stated)
REQ-031 in_data=1<<17, P=1 -> out_data=1<<14, out_valid 2 cycles after the accept cycle.
REQ-032 in_data=1<<12 (logical (0,0)), P=7 -> out_data=1<<12; random in_data with P=24 -> out_data=in_data.
REQ-033 P=0, in_data=0x1ABCDEF -> out_data=0x1ABCDEF one cycle after accept; in_ready=0 during DONE.
REQ-034 out_ready held 0 for 10 cycles in DONE -> out_valid and out_data stable; in_valid pulses in that window are ignored.
REQ-035 rst_n pulsed low mid-RUN with P=20 -> out_valid=0 and in_ready=1 immediately; the next job with P=1 completes correctly.
REQ-036 Macro defined, N=5, W=8: in_data with lane 17 = 0x01, P=1 -> lane 14 = 0x20, since source (1,0) gives rotation 5.
